// File: rtl/dotprod_sched.sv
// Sequencer and RAM-port arbiter between the host operand stream, the A/B operand RAMs
// and the dotprod core: loads vectors, runs the core with a timeout, captures the result.
module dotprod_sched #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 1024,
   parameter int TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_a,
   input  logic [DATA_W-1:0] load_b,
   input  logic              load_last,
   input  logic              start,
   output logic              busy,
   output logic              result_valid,
   output logic [DATA_W-1:0] result,
   output logic [1:0]        err,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic [DATA_W-1:0] ram_din_a,
   output logic [DATA_W-1:0] ram_din_b,
   output logic              dp_rst_n,
   output logic [31:0]       dp_n,
   input  logic [ADDR_W-1:0] dp_a_addr,
   input  logic [ADDR_W-1:0] dp_b_addr,
   input  logic              dp_done,
   input  logic [DATA_W-1:0] dp_result
);

   localparam int PTR_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CORE_RST,
      S_RUN,
      S_CAPTURE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_len;
   logic [31:0]       r_tcnt;
   logic [DATA_W-1:0] r_result;
   logic              r_result_valid;
   logic [1:0]        r_err;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr_a;
   logic [ADDR_W-1:0] r_addr_b;
   logic [DATA_W-1:0] r_din_a;
   logic [DATA_W-1:0] r_din_b;

   logic w_full;
   logic w_accept;
   logic w_overflow;
   logic w_timeout;
   logic w_start_run;
   logic w_start_zero;
   logic w_run;

   assign w_full = (r_wr_ptr == PTR_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      load_ready   = 1'b0;
      w_overflow   = 1'b0;
      w_timeout    = 1'b0;
      w_start_run  = 1'b0;
      w_start_zero = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (r_len != '0) begin
                  w_start_run = 1'b1;
                  w_next      = S_CORE_RST;
               end else begin
                  w_start_zero = 1'b1;
               end
            end else begin
               load_ready = 1'b1;
            end
         end
         S_LOAD: begin
            load_ready = !w_full;
            if (w_full && load_valid) begin
               w_overflow = 1'b1;
               w_next     = S_IDLE;
            end
         end
         S_CORE_RST: w_next = S_RUN;
         S_RUN: begin
            if (dp_done) begin
               w_next = S_CAPTURE;
            end else if (r_tcnt == 32'(TIMEOUT - 1)) begin
               w_timeout = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_CAPTURE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      if (rst) load_ready = 1'b0;
      w_accept = load_valid && load_ready;
      // The first beat out of IDLE is written like any other, so IDLE and LOAD share this path.
      if (w_accept) w_next = load_last ? S_IDLE : S_LOAD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_len          <= '0;
         r_tcnt         <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_err          <= '0;
         r_we           <= 1'b0;
         r_addr_a       <= '0;
         r_addr_b       <= '0;
         r_din_a        <= '0;
         r_din_b        <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_accept) begin
            r_we           <= 1'b1;
            r_addr_a       <= r_wr_ptr[ADDR_W-1:0];
            r_addr_b       <= r_wr_ptr[ADDR_W-1:0];
            r_din_a        <= load_a;
            r_din_b        <= load_b;
            r_len          <= r_wr_ptr + 1'b1;
            r_wr_ptr       <= load_last ? '0 : r_wr_ptr + 1'b1;
            r_err          <= '0;
            r_result_valid <= 1'b0;
         end
         if (w_overflow) begin
            r_err[0] <= 1'b1;
            r_wr_ptr <= '0;
         end
         if (w_start_run) begin
            r_err          <= '0;
            r_result_valid <= 1'b0;
         end
         if (w_start_zero) begin
            r_err          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b1;
         end
         if (r_state == S_CORE_RST) r_tcnt <= '0;
         if (r_state == S_RUN) begin
            r_tcnt   <= r_tcnt + 32'd1;
            r_addr_a <= dp_a_addr;
            r_addr_b <= dp_b_addr;
            if (dp_done) begin
               r_result       <= dp_result;
               r_result_valid <= 1'b1;
            end
         end
         if (w_timeout) r_err[1] <= 1'b1;
      end
   end

   assign w_run        = (r_state == S_RUN) && !rst;
   assign busy         = (r_state != S_IDLE);
   assign result_valid = r_result_valid;
   assign result       = r_result;
   assign err          = r_err;
   assign ram_we       = r_we && (r_state != S_RUN);
   assign ram_addr_a   = w_run ? dp_a_addr : r_addr_a;
   assign ram_addr_b   = w_run ? dp_b_addr : r_addr_b;
   assign ram_din_a    = r_din_a;
   assign ram_din_b    = r_din_b;
   assign dp_rst_n     = w_run;
   assign dp_n         = 32'(r_len);

endmodule

// File: tb/tb_dotprod_sched.sv
// Directed bench for dotprod_sched with a scripted core: load, run, zero-length start,
// overflow, timeout and mid-run reset, all against hand-computed values.
module tb_dotprod_sched;

   localparam int DW = 32;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_valid;
   logic          load_ready;
   logic [DW-1:0] load_a;
   logic [DW-1:0] load_b;
   logic          load_last;
   logic          start;
   logic          busy;
   logic          result_valid;
   logic [DW-1:0] result;
   logic [1:0]    err;
   logic          ram_we;
   logic [AW-1:0] ram_addr_a;
   logic [AW-1:0] ram_addr_b;
   logic [DW-1:0] ram_din_a;
   logic [DW-1:0] ram_din_b;
   logic          dp_rst_n;
   logic [31:0]   dp_n;
   logic [AW-1:0] dp_a_addr;
   logic [AW-1:0] dp_b_addr;
   logic          dp_done;
   logic [DW-1:0] dp_result;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dotprod_sched #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .DEPTH  (4),
      .TIMEOUT(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_a      (load_a),
      .load_b      (load_b),
      .load_last   (load_last),
      .start       (start),
      .busy        (busy),
      .result_valid(result_valid),
      .result      (result),
      .err         (err),
      .ram_we      (ram_we),
      .ram_addr_a  (ram_addr_a),
      .ram_addr_b  (ram_addr_b),
      .ram_din_a   (ram_din_a),
      .ram_din_b   (ram_din_b),
      .dp_rst_n    (dp_rst_n),
      .dp_n        (dp_n),
      .dp_a_addr   (dp_a_addr),
      .dp_b_addr   (dp_b_addr),
      .dp_done     (dp_done),
      .dp_result   (dp_result)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One accepted beat; the registered write must appear in the following cycle.
   task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last,
                            input logic [15:0] addr);
      load_valid = 1'b1;
      load_a     = a;
      load_b     = b;
      load_last  = last;
      #1 check("beat_ready", load_ready, 1);
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("wr_we", ram_we, 1);
      check("wr_addr_a", ram_addr_a, addr);
      check("wr_addr_b", ram_addr_b, addr);
      check("wr_din_a", ram_din_a, a);
      check("wr_din_b", ram_din_b, b);
   endtask

   task automatic run_core(input logic [31:0] res, input logic [31:0] n, input int lat);
      start = 1'b1;
      #1 check("start_blocks_ready", load_ready, 0);
      @(negedge clk);
      start = 1'b0;
      check("crst_rst_n", dp_rst_n, 0);
      check("crst_dp_n", dp_n, n);
      check("crst_busy", busy, 1);
      check("crst_rv", result_valid, 0);
      @(negedge clk);
      check("run_rst_n", dp_rst_n, 1);
      for (int i = 0; i < lat; i++) begin
         dp_a_addr = 16'(i + 1);
         dp_b_addr = 16'(i + 8);
         #1;
         check("run_pass_a", ram_addr_a, 16'(i + 1));
         check("run_pass_b", ram_addr_b, 16'(i + 8));
         check("run_we", ram_we, 0);
         @(negedge clk);
      end
      dp_done   = 1'b1;
      dp_result = res;
      @(negedge clk);
      dp_done   = 1'b0;
      dp_result = '0;
      check("cap_result", result, res);
      check("cap_rv", result_valid, 1);
      check("cap_rst_n", dp_rst_n, 0);
      check("cap_busy", busy, 1);
      @(negedge clk);
      check("post_busy", busy, 0);
      check("post_result", result, res);
   endtask

   initial begin
      int run_cnt;
      rst        = 1'b1;
      load_valid = 1'b0;
      load_a     = '0;
      load_b     = '0;
      load_last  = 1'b0;
      start      = 1'b0;
      dp_a_addr  = '0;
      dp_b_addr  = '0;
      dp_done    = 1'b0;
      dp_result  = '0;
      #1 check("rst_cycle_ready", load_ready, 0);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_rv", result_valid, 0);
      check("rst_result", result, 0);
      check("rst_err", err, 0);
      check("rst_we", ram_we, 0);
      check("rst_addr_a", ram_addr_a, 0);
      check("rst_rst_n", dp_rst_n, 0);
      check("rst_dp_n", dp_n, 0);
      check("rst_ready", load_ready, 0);
      rst = 1'b0;
      #1 check("idle_ready", load_ready, 1);

      // zero-length start, with a competing beat that must lose
      start      = 1'b1;
      load_valid = 1'b1;
      load_a     = 32'd99;
      #1 check("zero_start_ready", load_ready, 0);
      @(negedge clk);
      start      = 1'b0;
      load_valid = 1'b0;
      check("zero_rv", result_valid, 1);
      check("zero_result", result, 0);
      check("zero_busy", busy, 0);
      check("zero_we", ram_we, 0);
      check("zero_rst_n", dp_rst_n, 0);

      // load A={1,2,3,4} B={5,6,7,8}
      send_beat(32'd1, 32'd5, 1'b0, 16'd0);
      check("load_rv_cleared", result_valid, 0);
      check("load_busy", busy, 1);
      send_beat(32'd2, 32'd6, 1'b0, 16'd1);
      send_beat(32'd3, 32'd7, 1'b0, 16'd2);
      send_beat(32'd4, 32'd8, 1'b1, 16'd3);
      check("load_idle", busy, 0);
      check("load_len", dp_n, 4);
      @(negedge clk);
      check("load_we_off", ram_we, 0);

      // 1*5+2*6+3*7+4*8 = 70
      run_core(32'd70, 32'd4, 3);

      // overflow with DEPTH=4
      send_beat(32'd11, 32'd21, 1'b0, 16'd0);
      send_beat(32'd12, 32'd22, 1'b0, 16'd1);
      send_beat(32'd13, 32'd23, 1'b0, 16'd2);
      send_beat(32'd14, 32'd24, 1'b0, 16'd3);
      load_valid = 1'b1;
      load_a     = 32'd15;
      load_b     = 32'd25;
      #1 check("full_ready", load_ready, 0);
      @(negedge clk);
      load_valid = 1'b0;
      check("ovf_err", err, 2'b01);
      check("ovf_no_write", ram_we, 0);
      check("ovf_len", dp_n, 4);
      check("ovf_busy", busy, 0);
      check("ovf_rv", result_valid, 0);

      // timeout with dp_done held low
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("to_err_cleared", err, 0);
      check("to_crst_rst_n", dp_rst_n, 0);
      run_cnt = 0;
      @(negedge clk);
      while (dp_rst_n === 1'b1 && run_cnt < 40) begin
         run_cnt++;
         @(negedge clk);
      end
      check("to_run_cycles", run_cnt, 16);
      check("to_err", err, 2'b10);
      check("to_busy", busy, 0);
      check("to_rv", result_valid, 0);
      check("to_rst_n", dp_rst_n, 0);

      // reset in the middle of RUN
      send_beat(32'd3, 32'd10, 1'b0, 16'd0);
      check("beat_err_cleared", err, 0);
      send_beat(32'd4, 32'd20, 1'b1, 16'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_run_rst_n", dp_rst_n, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_busy", busy, 0);
      check("mrst_rst_n", dp_rst_n, 0);
      check("mrst_rv", result_valid, 0);
      check("mrst_err", err, 0);
      check("mrst_we", ram_we, 0);
      check("mrst_addr_a", ram_addr_a, 0);
      check("mrst_addr_b", ram_addr_b, 0);
      check("mrst_din_a", ram_din_a, 0);
      check("mrst_dp_n", dp_n, 0);
      #1 check("mrst_ready", load_ready, 1);

      // 3*10+4*20 = 110
      send_beat(32'd3, 32'd10, 1'b0, 16'd0);
      send_beat(32'd4, 32'd20, 1'b1, 16'd1);
      run_core(32'd110, 32'd2, 3);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
